// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, RV32I opcode/funct7 constants, decoded entry.
// Imported by the issue stage, its decoder and the ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int ENTRY_W = 75;

  typedef struct packed {
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/alu_op_decode.sv
// Purpose: decode an RV32I OP/OP-IMM/LUI/AUIPC instruction into an ALU request entry.
// Latency: combinational.
// Backpressure: none; the enclosing stage owns the handshake.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output entry_t      dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_shift;
  logic        f7_ok;
  logic [3:0]  base_op;
  logic        legal;
  logic [3:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        unused_fields;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  // The alternate funct7 only selects SUB/SRA, so it is legal solely with funct3 000/101.
  assign f7_ok    = (funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
  assign unused_fields = ^instr[19:15];

  always_comb begin
    base_op = ALU_ADD;
    case (funct3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    op    = ALU_ADD;
    opa   = '0;
    opb   = '0;
    case (opcode)
      OPC_OP: begin
        legal = f7_ok;
        opa   = rs1;
        opb   = rs2;
        if (funct7 == F7_ALT) op = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
        else                  op = base_op;
      end
      OPC_OP_IMM: begin
        opa = rs1;
        if (is_shift) begin
          legal = f7_ok;
          opb   = {27'b0, instr[24:20]};
          op    = (funct7 == F7_ALT) ? ALU_SRA : base_op;
        end else begin
          // funct7 bits are immediate here, so ADDI ignores them
          legal = 1'b1;
          opb   = {{20{instr[31]}}, instr[31:20]};
          op    = base_op;
        end
      end
      OPC_LUI: begin
        legal = 1'b1;
        opb   = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        opa   = pc;
        opb   = {instr[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    dec           = '0;
    dec.operand_a = legal ? opa : 32'd0;
    dec.operand_b = legal ? opb : 32'd0;
    dec.alu_op    = legal ? op : ALU_ADD;
    dec.rd        = instr[11:7];
    dec.rd_we     = legal && (instr[11:7] != 5'd0);
    dec.illegal   = !legal;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Purpose: registered decode/issue stage feeding the ALU request interface.
// Latency: one cycle from accept to out_valid when the main entry is empty.
// Backpressure: two-entry skid buffer; registered in_ready drops once the skid entry fills.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_operand_a,
  output logic [31:0] out_operand_b,
  output logic [3:0]  out_alu_op,
  output logic [4:0]  out_rd,
  output logic        out_rd_we,
  output logic        out_illegal
);

  entry_t dec_entry;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_vld, main_vld_d;
  logic   skid_vld, skid_vld_d;
  logic   accept;
  logic   drain;

  alu_op_decode u_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .rs1   (in_rs1_data),
    .rs2   (in_rs2_data),
    .dec   (dec_entry)
  );

  assign accept = in_valid && in_ready;
  assign drain  = main_vld && out_ready;

  // in_ready is low whenever skid is full, so accept never coincides with a full skid.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld;
    skid_vld_d = skid_vld;
    if (drain) begin
      if (skid_vld) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = dec_entry;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_vld) begin
        main_d     = dec_entry;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = dec_entry;
        skid_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_vld <= main_vld_d;
      skid_vld <= skid_vld_d;
      in_ready <= !skid_vld_d;
    end
  end

  assign out_valid     = main_vld;
  assign out_operand_a = main_q.operand_a;
  assign out_operand_b = main_q.operand_b;
  assign out_alu_op    = main_q.alu_op;
  assign out_rd        = main_q.rd;
  assign out_rd_we     = main_q.rd_we;
  assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized scoreboard bench for alu_issue_stage against a behavioural RV32I decode model.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_operand_a;
  logic [31:0] out_operand_b;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .in_rs1_data   (in_rs1_data),
    .in_rs2_data   (in_rs2_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_operand_a (out_operand_a),
    .out_operand_b (out_operand_b),
    .out_alu_op    (out_alu_op),
    .out_rd        (out_rd),
    .out_rd_we     (out_rd_we),
    .out_illegal   (out_illegal)
  );

  int        n_checks = 0;
  int        n_fail   = 0;
  int        cyc      = 0;
  entry_t    sb[$];
  logic [3:0] f3op [8];
  logic [74:0] cur_out;
  logic [74:0] prev_out;
  logic      prev_stall = 1'b0;
  logic      stream_on  = 1'b0;
  int        stream_last = -1;
  int        stream_cnt  = 0;

  assign cur_out = {out_operand_a, out_operand_b, out_alu_op, out_rd, out_rd_we, out_illegal};

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [74:0] act, input logic [74:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2f,
                                      input logic [4:0] rs1f, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2f, rs1f, f3, rd, opc};
  endfunction

  // Reference decode from the ISA rules; SUB/SRA sit one code above ADD/SRL.
  function automatic entry_t ref_dec(input logic [31:0] i, input logic [31:0] pc,
                                     input logic [31:0] r1, input logic [31:0] r2);
    entry_t     e;
    logic       legal;
    logic       alt;
    logic       f7_ok;
    logic [2:0] f3;
    logic [6:0] f7;
    f3    = i[14:12];
    f7    = i[31:25];
    alt   = (f7 == 7'h20);
    f7_ok = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
    e     = '0;
    e.rd  = i[11:7];
    legal = 1'b0;
    case (i[6:0])
      7'h33: begin
        legal = f7_ok; e.operand_a = r1; e.operand_b = r2;
        e.alu_op = f3op[f3] + {3'b0, alt};
      end
      7'h13: begin
        e.operand_a = r1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          legal = f7_ok; e.operand_b = {27'b0, i[24:20]};
          e.alu_op = f3op[f3] + {3'b0, alt};
        end else begin
          legal = 1'b1; e.operand_b = {{20{i[31]}}, i[31:20]}; e.alu_op = f3op[f3];
        end
      end
      7'h37: begin legal = 1'b1; e.operand_a = 32'd0; e.operand_b = {i[31:12], 12'b0}; e.alu_op = 4'd0; end
      7'h17: begin legal = 1'b1; e.operand_a = pc;    e.operand_b = {i[31:12], 12'b0}; e.alu_op = 4'd0; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.operand_a = 32'd0; e.operand_b = 32'd0; e.alu_op = 4'd0;
    end
    e.illegal = !legal;
    e.rd_we   = legal && (i[11:7] != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_legal(input int k);
    logic [31:0] r;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1f;
    logic [4:0]  rs2f;
    int          cls;
    r    = $urandom;
    rd   = (k % 5 == 0) ? 5'd0 : r[4:0];
    f3   = r[7:5];
    rs1f = r[12:8];
    rs2f = r[17:13];
    cls  = $urandom_range(0, 3);
    case (cls)
      0: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[18]) ? 7'h20 : 7'h00;
        return enc(f7, rs2f, rs1f, f3, rd, 7'h33);
      end
      1: begin
        if (f3 == 3'd1)      f7 = 7'h00;
        else if (f3 == 3'd5) f7 = r[18] ? 7'h20 : 7'h00;
        else                 f7 = r[25:19];
        return enc(f7, rs2f, rs1f, f3, rd, 7'h13);
      end
      2:       return {r[31:12], rd, 7'h37};
      default: return {r[31:12], rd, 7'h17};
    endcase
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the entry.
  task automatic send(input logic [31:0] i, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2);
    bit done = 1'b0;
    in_valid = 1'b1; in_instr = i; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
    for (int w = 0; w < 100 && !done; w++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(ref_dec(i, pc, r1, r2));
        done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for instr %h", i);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic we, input logic ill);
    @(negedge clk);
    chk_int({nm, "_latency"}, int'(out_valid), 1);
    chk(nm, {5'd0, out_operand_a, out_operand_b, out_alu_op, out_rd_we, out_illegal},
        {5'd0, a, b, op, we, ill});
    @(posedge clk); #1;
  endtask

  task automatic wait_drained(input string nm);
    for (int w = 0; w < 200 && sb.size() != 0; w++) @(negedge clk);
    chk_int(nm, sb.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk_int("valid_hold", int'(out_valid), 1);
        chk("hold_stable", cur_out, prev_out);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got %h expected no transfer", cur_out);
        end else begin
          chk("decode", cur_out, sb.pop_front());
          if (out_rd == 5'd0) chk_int("rd0_no_we", int'(out_rd_we), 0);
          if (stream_on) begin
            if (stream_last >= 0) chk_int("stream_gap", cyc - stream_last, 1);
            stream_last = cyc;
            stream_cnt++;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = cur_out;
    end
  end

  initial begin
    f3op[0] = 4'd0; f3op[1] = 4'd7; f3op[2] = 4'd2; f3op[3] = 4'd3;
    f3op[4] = 4'd4; f3op[5] = 4'd8; f3op[6] = 4'd5; f3op[7] = 4'd6;
    in_valid = 1'b0; in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    chk_int("reset_out_valid", int'(out_valid), 0);
    chk_int("reset_in_ready", int'(in_ready), 1);
    chk("reset_data", cur_out, 75'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    send(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h0, 32'd5, 32'd7);
    expect_out("add", 32'd5, 32'd7, 4'd0, 1'b1, 1'b0);
    send(enc(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h0, 32'd5, 32'd7);
    expect_out("sub", 32'd5, 32'd7, 4'd1, 1'b1, 1'b0);
    send({12'hFFF, 5'd1, 3'd0, 5'd4, 7'h13}, 32'h0, 32'd5, 32'd9);
    expect_out("addi", 32'd5, 32'hFFFF_FFFF, 4'd0, 1'b1, 1'b0);
    send(enc(7'h20, 5'd3, 5'd1, 3'd5, 5'd5, 7'h13), 32'h0, 32'h8000_0000, 32'd9);
    expect_out("srai", 32'h8000_0000, 32'd3, 4'd9, 1'b1, 1'b0);
    send(enc(7'h20, 5'd2, 5'd1, 3'd1, 5'd6, 7'h13), 32'h0, 32'd5, 32'd9);
    expect_out("slli_bad_f7", 32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
    send({20'h12345, 5'd6, 7'h37}, 32'h40, 32'd5, 32'd9);
    expect_out("lui", 32'd0, 32'h1234_5000, 4'd0, 1'b1, 1'b0);
    send({20'h12345, 5'd7, 7'h17}, 32'h100, 32'd5, 32'd9);
    expect_out("auipc", 32'h100, 32'h1234_5000, 4'd0, 1'b1, 1'b0);
    send({12'h004, 5'd1, 3'd2, 5'd8, 7'h03}, 32'h0, 32'd5, 32'd9);
    expect_out("load_illegal", 32'd0, 32'd0, 4'd0, 1'b0, 1'b1);

    // Backpressure: main and skid fill, third instruction waits upstream.
    out_ready = 1'b0;
    send(enc(7'h00, 5'd2, 5'd1, 3'd4, 5'd9,  7'h33), 32'h0, 32'h1111, 32'h2222);
    send(enc(7'h00, 5'd2, 5'd1, 3'd6, 5'd10, 7'h33), 32'h0, 32'h3333, 32'h4444);
    @(negedge clk);
    chk_int("bp_in_ready_low", int'(in_ready), 0);
    fork
      send(enc(7'h00, 5'd2, 5'd1, 3'd7, 5'd11, 7'h33), 32'h0, 32'h5555, 32'h6666);
    join_none
    repeat (3) @(negedge clk);
    chk_int("bp_third_held", sb.size(), 2);
    chk_int("bp_in_ready_still_low", int'(in_ready), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    wait_drained("bp_all_out");

    stream_on = 1'b1; stream_last = -1; stream_cnt = 0;
    for (int k = 0; k < 20; k++) send(rand_legal(k), $urandom, $urandom, $urandom);
    wait_drained("stream_drained");
    stream_on = 1'b0;
    chk_int("stream_count", stream_cnt, 20);

    // Asynchronous reset with both entries occupied.
    out_ready = 1'b0;
    send(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd12, 7'h33), 32'h0, 32'd1, 32'd2);
    send(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd13, 7'h33), 32'h0, 32'd3, 32'd4);
    #2;
    chk_int("pre_reset_full", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk_int("rst_in_ready", int'(in_ready), 1);
    chk("rst_data", cur_out, 75'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(enc(7'h00, 5'd2, 5'd1, 3'd3, 5'd14, 7'h33), 32'h0, 32'd8, 32'd9);
    expect_out("post_reset_sltu", 32'd8, 32'd9, 4'd3, 1'b1, 1'b0);
    wait_drained("final_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
